cordic_atan2: RTL and testbench



---
 rtl/cordic_atan2.sv | 151 +++++++++++++++
 tb/tb_cordic_atan2.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_atan2.sv
// Pipelined vectoring-mode CORDIC: signed (X, Y) in, full-turn phase and amplitude out.
// One sample per CE-enabled clock, fixed latency of STAGES+2 registers.
module cordic_atan2 #(
    parameter int DATA_BITS       = 16,
    parameter int PHASE_BITS      = 16,
    parameter int STAGES          = 16,
    parameter int EXTRA_DATA_BITS = 5
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  CE,
    input  logic                  IN_VALID,
    input  logic [DATA_BITS-1:0]  X_IN,
    input  logic [DATA_BITS-1:0]  Y_IN,
    output logic                  OUT_VALID,
    output logic [PHASE_BITS-1:0] PHASE,
    output logic [DATA_BITS:0]    MAGNITUDE
);

    localparam int LATENCY = STAGES + 2;
    localparam int W       = DATA_BITS + EXTRA_DATA_BITS + 2;
    localparam int ZW      = PHASE_BITS + 4;
    localparam int PROD_W  = W + 18;
    localparam int MAG_K   = 79594;
    localparam real PI     = 3.14159265358979323846;
    localparam logic [PROD_W-1:0] MAG_MAX = PROD_W'((64'd1 << (DATA_BITS + 1)) - 64'd1);

    // atan(2^-idx) as a fraction of a full turn, scaled to the Z accumulator width.
    function automatic logic [ZW-1:0] angle_of(input int idx);
        real t;
        real t2;
        real term;
        real acc;
        real scale;
        if (idx == 0) begin
            acc = PI / 4.0;
        end else begin
            t = 1.0;
            for (int j = 0; j < idx; j++) t = t / 2.0;
            t2   = t * t;
            term = t;
            acc  = 0.0;
            for (int k = 0; k < 24; k++) begin
                if (k % 2 == 0) acc = acc + term / $itor(2 * k + 1);
                else            acc = acc - term / $itor(2 * k + 1);
                term = term * t2;
            end
        end
        scale = 1.0;
        for (int j = 0; j < ZW; j++) scale = scale * 2.0;
        return ZW'($rtoi(acc / (2.0 * PI) * scale + 0.5));
    endfunction

    logic signed [W-1:0]  x_pipe     [0:LATENCY-2];
    logic signed [W-1:0]  y_pipe     [0:LATENCY-2];
    logic        [ZW-1:0] z_pipe     [0:LATENCY-2];
    logic                 valid_pipe [0:LATENCY-2];
    logic                 zero_pipe  [0:LATENCY-2];

    logic signed [W-1:0] x_ext;
    logic signed [W-1:0] y_ext;

    assign x_ext = {{(W-DATA_BITS){X_IN[DATA_BITS-1]}}, X_IN} <<< EXTRA_DATA_BITS;
    assign y_ext = {{(W-DATA_BITS){Y_IN[DATA_BITS-1]}}, Y_IN} <<< EXTRA_DATA_BITS;

    // Fold the left half-plane onto the right by a half-turn rotation.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            x_pipe[0]     <= '0;
            y_pipe[0]     <= '0;
            z_pipe[0]     <= '0;
            valid_pipe[0] <= 1'b0;
            zero_pipe[0]  <= 1'b0;
        end else if (CE) begin
            if (X_IN[DATA_BITS-1]) begin
                x_pipe[0] <= -x_ext;
                y_pipe[0] <= -y_ext;
                z_pipe[0] <= ZW'(1) << (ZW - 1);
            end else begin
                x_pipe[0] <= x_ext;
                y_pipe[0] <= y_ext;
                z_pipe[0] <= '0;
            end
            valid_pipe[0] <= IN_VALID;
            zero_pipe[0]  <= (X_IN == '0) && (Y_IN == '0);
        end
    end

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        localparam logic [ZW-1:0] ANG = angle_of(k - 1);

        logic signed [W-1:0] x_sh;
        logic signed [W-1:0] y_sh;

        assign x_sh = x_pipe[k-1] >>> (k - 1);
        assign y_sh = y_pipe[k-1] >>> (k - 1);

        always_ff @(posedge CLK) begin
            if (RESET) begin
                x_pipe[k]     <= '0;
                y_pipe[k]     <= '0;
                z_pipe[k]     <= '0;
                valid_pipe[k] <= 1'b0;
                zero_pipe[k]  <= 1'b0;
            end else if (CE) begin
                if (!y_pipe[k-1][W-1]) begin
                    x_pipe[k] <= x_pipe[k-1] + y_sh;
                    y_pipe[k] <= y_pipe[k-1] - x_sh;
                    z_pipe[k] <= z_pipe[k-1] + ANG;
                end else begin
                    x_pipe[k] <= x_pipe[k-1] - y_sh;
                    y_pipe[k] <= y_pipe[k-1] + x_sh;
                    z_pipe[k] <= z_pipe[k-1] - ANG;
                end
                valid_pipe[k] <= valid_pipe[k-1];
                zero_pipe[k]  <= zero_pipe[k-1];
            end
        end
    end

    // Remove the CORDIC gain with a fixed-point 1/K multiply and round.
    logic [W-1:0]      x_pos;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] mag_sh;

    assign x_pos  = x_pipe[STAGES][W-1] ? '0 : x_pipe[STAGES];
    assign prod   = PROD_W'(x_pos) * PROD_W'(MAG_K) + (PROD_W'(1) << (16 + EXTRA_DATA_BITS));
    assign mag_sh = prod >> (17 + EXTRA_DATA_BITS);

    logic unused_bits;
    assign unused_bits = ^{z_pipe[STAGES][3:0], y_pipe[STAGES]};

    // Invalid slots drive zeros so the outputs stay deterministic.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            OUT_VALID <= 1'b0;
            PHASE     <= '0;
            MAGNITUDE <= '0;
        end else if (CE) begin
            OUT_VALID <= valid_pipe[STAGES];
            PHASE     <= (valid_pipe[STAGES] && !zero_pipe[STAGES]) ? z_pipe[STAGES][ZW-1:4] : '0;
            if (!valid_pipe[STAGES])
                MAGNITUDE <= '0;
            else if (mag_sh > MAG_MAX)
                MAGNITUDE <= MAG_MAX[DATA_BITS:0];
            else
                MAGNITUDE <= mag_sh[DATA_BITS:0];
        end
    end

endmodule

// File: tb/tb_cordic_atan2.sv
// Directed-vector bench for cordic_atan2: table vectors, CE stall, mid-stream reset,
// and a full-circle round trip, all checked against a scoreboard of expected edge numbers.
module tb_cordic_atan2;

    logic        CLK      = 1'b0;
    logic        RESET    = 1'b1;
    logic        CE       = 1'b1;
    logic        IN_VALID = 1'b0;
    logic [15:0] X_IN     = '0;
    logic [15:0] Y_IN     = '0;
    logic        OUT_VALID;
    logic [15:0] PHASE;
    logic [16:0] MAGNITUDE;

    cordic_atan2 dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .CE        (CE),
        .IN_VALID  (IN_VALID),
        .X_IN      (X_IN),
        .Y_IN      (Y_IN),
        .OUT_VALID (OUT_VALID),
        .PHASE     (PHASE),
        .MAGNITUDE (MAGNITUDE)
    );

    always #5 CLK = ~CLK;

    localparam real PI = 3.14159265358979323846;
    localparam int  NV = 10;

    typedef struct {
        int x;
        int y;
        int ph;
        int ph_tol;
        int mag;
        int mag_tol;
    } vec_t;

    typedef struct {
        int ph;
        int ph_tol;
        int mag;
        int mag_tol;
        int edge_n;
    } exp_t;

    vec_t vecs [NV];
    vec_t cur;
    exp_t q [$];
    exp_t e;

    int tests    = 0;
    int fails    = 0;
    int ce_edges = 0;
    bit last_act = 1'b0;
    bit last_rst = 1'b0;

    int     rt_on   = 0;
    int     err_max = 0;
    longint err_sum = 0;
    int     rt_n    = 0;

    logic        prev_ov;
    logic [15:0] prev_ph;
    logic [16:0] prev_mag;

    function automatic int phase_err(input int a, input int r);
        int d;
        d = (a - r) & 32'hFFFF;
        if (d > 32767) d = d - 65536;
        return (d < 0) ? -d : d;
    endfunction

    task automatic chk(input string name, input int act, input int req, input int tol, input bit wrap);
        int d;
        tests++;
        if (wrap) d = phase_err(act, req);
        else      d = (act > req) ? act - req : req - act;
        if (d > tol) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d (t=%0t)", name, act, req, tol, $time);
        end
    endtask

    // Capture model: each accepted valid sample must appear after CE edge number +17.
    always @(posedge CLK) begin
        last_rst = RESET;
        last_act = !RESET && CE;
        if (RESET) begin
            q.delete();
        end else if (CE) begin
            ce_edges++;
            if (IN_VALID) q.push_back('{cur.ph, cur.ph_tol, cur.mag, cur.mag_tol, ce_edges + 17});
        end
    end

    always @(negedge CLK) begin
        bit exp_ov;
        int d;
        if (last_rst) begin
            chk("reset_ov", int'(OUT_VALID), 0, 0, 1'b0);
            chk("reset_phase", int'(PHASE), 0, 0, 1'b0);
            chk("reset_mag", int'(MAGNITUDE), 0, 0, 1'b0);
        end else if (last_act) begin
            exp_ov = (q.size() > 0) && (q[0].edge_n == ce_edges);
            chk("out_valid", int'(OUT_VALID), int'(exp_ov), 0, 1'b0);
            if (exp_ov) begin
                e = q.pop_front();
                if (OUT_VALID) begin
                    chk("phase", int'(PHASE), e.ph, e.ph_tol, 1'b1);
                    chk("magnitude", int'(MAGNITUDE), e.mag, e.mag_tol, 1'b0);
                    if (rt_on != 0) begin
                        d = phase_err(int'(PHASE), e.ph);
                        if (d > err_max) err_max = d;
                        err_sum += d;
                        rt_n++;
                    end
                end
            end
        end else begin
            chk("stall_ov", int'(OUT_VALID), int'(prev_ov), 0, 1'b0);
            chk("stall_phase", int'(PHASE), int'(prev_ph), 0, 1'b0);
            chk("stall_mag", int'(MAGNITUDE), int'(prev_mag), 0, 1'b0);
        end
        prev_ov  = OUT_VALID;
        prev_ph  = PHASE;
        prev_mag = MAGNITUDE;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input vec_t v, input bit vld);
        X_IN     = 16'(v.x);
        Y_IN     = 16'(v.y);
        IN_VALID = vld;
        cur      = v;
        tick();
    endtask

    task automatic drain();
        int k;
        IN_VALID = 1'b0;
        k = 0;
        while (q.size() > 0 && k < 60) begin
            tick();
            k++;
        end
        chk("drain_pending", q.size(), 0, 0, 1'b0);
        q.delete();
    endtask

    function automatic int rnd(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    initial begin
        vec_t rt;
        real  a;

        vecs[0] = '{ 32767,      0, 16'h0000, 1, 32767, 2};
        vecs[1] = '{     0,  32767, 16'h4000, 1, 32767, 2};
        vecs[2] = '{-32767,      0, 16'h8000, 1, 32767, 2};
        vecs[3] = '{     0, -32767, 16'hC000, 1, 32767, 2};
        vecs[4] = '{-32768, -32768, 16'hA000, 1, 46341, 2};
        vecs[5] = '{ 32767, -32768, 16'hE000, 1, 46340, 2};
        vecs[6] = '{     0,      0, 16'h0000, 0,     0, 0};
        vecs[7] = '{ 23170,  23170, 16'h2000, 1, 32767, 2};
        vecs[8] = '{-23170,  23170, 16'h6000, 1, 32767, 2};
        vecs[9] = '{ 30274,  12540, 16'h1000, 1, 32768, 2};

        repeat (10) tick();
        RESET = 1'b0;
        for (int i = 0; i < 18; i++) begin
            tick();
            chk("idle_ov", int'(OUT_VALID), 0, 0, 1'b0);
            chk("idle_phase", int'(PHASE), 0, 0, 1'b0);
            chk("idle_mag", int'(MAGNITUDE), 0, 0, 1'b0);
        end

        for (int i = 0; i < NV; i++) begin
            send(vecs[i], 1'b1);
            drain();
        end

        for (int i = 0; i < 30; i++) send(vecs[i % NV], (i % 3) != 2);
        drain();

        for (int i = 0; i < 40; i++) begin
            if (i == 20) begin
                CE = 1'b0;
                repeat (5) tick();
                CE = 1'b1;
            end
            send(vecs[i % NV], 1'b1);
        end
        drain();

        for (int i = 0; i < 17; i++) send(vecs[i % NV], 1'b1);
        X_IN     = 16'(vecs[2].x);
        Y_IN     = 16'(vecs[2].y);
        IN_VALID = 1'b1;
        cur      = vecs[2];
        RESET    = 1'b1;
        tick();
        chk("midreset_ov", int'(OUT_VALID), 0, 0, 1'b0);
        RESET    = 1'b0;
        IN_VALID = 1'b0;
        repeat (5) tick();
        send(vecs[1], 1'b1);
        drain();

        rt_on = 1;
        for (int p = 0; p < 65536; p++) begin
            a  = 2.0 * PI * ($itor(p) + 0.5) / 65536.0;
            rt = '{rnd(32767.0 * $cos(a)), rnd(32767.0 * $sin(a)), p, 1, 32767, 2};
            send(rt, 1'b1);
        end
        drain();
        rt_on = 0;
        if (rt_n > 0)
            $display("[TB] round trip: %0d samples, max phase error %0d LSB, mean %f LSB",
                     rt_n, err_max, $itor(err_sum) / $itor(rt_n));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
